fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 16, instruction address width (word addressed)
- INST_W, 16, instruction width
- RESET_PC, 16'h0000, first fetch address after reset
REQ-002 Ports SHALL be, one per line:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset, asynchronous, active-low
- STALL  in  1  downstream IF/ID register not accepting; hold current instruction
- REDIRECT  in  1  taken branch/jump; flush and refetch from REDIRECT_PC
- REDIRECT_PC  in  ADDR_W  redirect target
- IMEM_REQ  out  1  instruction memory request
- IMEM_ADDR  out  ADDR_W  request address
- IMEM_ACK  in  1  IMEM_RDATA valid this cycle; completes request
- IMEM_RDATA  in  INST_W  fetched instruction
- INST_VALID  out  1  INST/INST_PC valid for downstream
- INST  out  INST_W  instruction at buffer head
- INST_PC  out  ADDR_W  address of INST
REQ-003 One clock (CLK); reset RST_N is asynchronous and active-low.

Function
REQ-004 Block SHALL hold a fetch PC, a 2-entry FIFO of {pc, inst}, and an FSM with states RUN, WAIT, DISCARD.
REQ-005 At most one memory request SHALL be outstanding; once IMEM_REQ rises, IMEM_REQ and IMEM_ADDR SHALL hold stable until the cycle IMEM_ACK is sampled high.
REQ-006 RUN: IMEM_REQ = 1 when FIFO count < 2, IMEM_ADDR = fetch PC; request issued -> WAIT; count == 2 -> IMEM_REQ = 0, stay RUN.
REQ-007 WAIT with IMEM_ACK: push {IMEM_ADDR, IMEM_RDATA}, fetch PC <= fetch PC + 1 (mod 2^ADDR_W, wraps 16'hFFFF -> 16'h0000), -> RUN.
REQ-008 INST_VALID SHALL be 1 iff FIFO count > 0; INST/INST_PC SHALL present the head entry; data acked into an empty FIFO SHALL appear on INST_VALID the next cycle (ack-to-valid latency 1).
REQ-009 Pop SHALL occur when INST_VALID && !STALL && !REDIRECT; while STALL = 1, INST and INST_PC SHALL stay unchanged.
REQ-010 Simultaneous push and pop SHALL keep count unchanged and preserve order; push at count 2 SHALL not occur (guaranteed by REQ-006).
REQ-011 REDIRECT SHALL have priority over STALL and ack: FIFO cleared (INST_VALID = 0 next cycle), fetch PC <= REDIRECT_PC.
REQ-012 REDIRECT in WAIT without IMEM_ACK -> DISCARD; DISCARD keeps old request held, drops the acked data, then -> RUN and issues REDIRECT_PC.
REQ-013 REDIRECT in the same cycle as IMEM_ACK: acked data dropped, -> RUN, REDIRECT_PC requested next cycle.
REQ-014 REDIRECT while in DISCARD SHALL update fetch PC to the newest REDIRECT_PC and remain in DISCARD.
REQ-015 INST_PC + 1 sequence SHALL be contiguous between redirects (no skipped or duplicated address).

Reset
REQ-016 RST_N low SHALL immediately force: FSM = RUN, FIFO count = 0, fetch PC = RESET_PC, IMEM_REQ = 0, IMEM_ADDR = RESET_PC, INST_VALID = 0, INST = 0, INST_PC = 0.
REQ-017 First posedge after RST_N release SHALL assert IMEM_REQ with IMEM_ADDR = RESET_PC.
REQ-018 Reset during an outstanding request SHALL abandon it; an IMEM_ACK arriving while RST_N low or before a new request SHALL be ignored.

Verification
REQ-019 Reset release, IMEM_ACK every cycle after REQ, STALL = 0 -> INST_PC 0,1,2,3 on consecutive cycles, INST matches memory.
REQ-020 STALL = 1 for 5 cycles with ack-immediately memory -> count saturates at 2, IMEM_REQ = 0, INST_PC held at 0; release -> 0,1,2 in order, no loss.
REQ-021 REDIRECT to 16'h0040 while request to 16'h0003 outstanding, ack 3 cycles later -> data for 3 dropped, next IMEM_ADDR = 16'h0040, next INST_PC = 16'h0040.
REQ-022 REDIRECT with IMEM_ACK same cycle, target 16'h0100 -> acked word never valid, IMEM_ADDR = 16'h0100 next cycle.
REQ-023 Redirect to 16'hFFFF, free-running -> INST_PC 16'hFFFF then 16'h0000.
REQ-024 RST_N asserted mid-WAIT with STALL = 1 and count 2 -> outputs at REQ-016 values asynchronously, late ack ignored, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with 2-entry instruction buffer
//
// Purpose:
//   Fetches instructions from a request/acknowledge instruction memory and
//   buffers up to two {pc, inst} pairs for the decode stage. At most one memory
//   request is outstanding. A redirect flushes the buffer and restarts fetch
//   at a new address.
//
// Ports:
//   CLK          clock, all state updates on posedge
//   RST_N        asynchronous active-low reset
//   STALL        downstream not accepting; head entry is held
//   REDIRECT     flush buffer and refetch from REDIRECT_PC
//   REDIRECT_PC  redirect target address
//   IMEM_REQ     memory request (held until IMEM_ACK)
//   IMEM_ADDR    memory request address (held until IMEM_ACK)
//   IMEM_ACK     IMEM_RDATA valid; completes the outstanding request
//   IMEM_RDATA   fetched instruction
//   INST_VALID   buffer head valid
//   INST         instruction at buffer head
//   INST_PC      address of INST

module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [INST_W-1:0] IMEM_RDATA,
  output logic              INST_VALID,
  output logic [INST_W-1:0] INST,
  output logic [ADDR_W-1:0] INST_PC
);

  // RUN: no request outstanding. WAIT: request outstanding, data will be kept.
  // DISCARD: request outstanding, but a redirect happened; its data is dropped.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;        // next address to fetch
  logic [1:0]          cnt_q, cnt_d;      // buffer occupancy 0..2
  logic [ADDR_W-1:0]   pc0_q, pc0_d;      // slot 0 is always the head
  logic [INST_W-1:0]   inst0_q, inst0_d;
  logic [ADDR_W-1:0]   pc1_q, pc1_d;
  logic [INST_W-1:0]   inst1_q, inst1_d;

  logic                push;
  logic                pop;
  logic                slot_free;
  logic [1:0]          fill;

  always_comb begin
    push      = (state_q == ST_WAIT) && IMEM_ACK && !REDIRECT;
    pop       = (cnt_q != 2'd0) && !STALL && !REDIRECT;
    // The request channel is free if nothing is outstanding or the
    // outstanding request completes this cycle.
    slot_free = (state_q == ST_RUN) || IMEM_ACK;
    // Occupancy left after the pop; the pushed entry lands right behind it.
    fill      = cnt_q - {1'b0, pop};

    // Buffer
    cnt_d   = cnt_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;
    if (REDIRECT) begin
      cnt_d = 2'd0;
    end else begin
      cnt_d = fill + {1'b0, push};
      if (pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (push) begin
        if (fill == 2'd0) begin
          pc0_d   = addr_q;
          inst0_d = IMEM_RDATA;
        end else begin
          pc1_d   = addr_q;
          inst1_d = IMEM_RDATA;
        end
      end
    end

    // Fetch PC
    if (REDIRECT) begin
      pc_d = REDIRECT_PC;
    end else if (push) begin
      pc_d = pc_q + 1'b1;
    end else begin
      pc_d = pc_q;
    end

    // Request FSM. When a request completes and there is room, the unit
    // passes through RUN within the same cycle and issues the next request
    // straight away, so back-to-back fetches need no idle cycle.
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    if (slot_free) begin
      if (cnt_d != 2'd2) begin
        state_d = ST_WAIT;
        req_d   = 1'b1;
        addr_d  = pc_d;
      end else begin
        state_d = ST_RUN;
        req_d   = 1'b0;
      end
    end else if (REDIRECT) begin
      // Old request must stay on the bus until acked; remember to drop it.
      state_d = ST_DISCARD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      pc0_q   <= '0;
      inst0_q <= '0;
      pc1_q   <= '0;
      inst1_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
    end
  end

  assign IMEM_REQ   = req_q;
  assign IMEM_ADDR  = addr_q;
  assign INST_VALID = (cnt_q != 2'd0);
  assign INST       = inst0_q;
  assign INST_PC    = pc0_q;

endmodule
